// File: rtl/bcd_stopwatch_counter.sv
// -----------------------------------------------------------------------------
// bcd_stopwatch_counter
//
// MM:SS stopwatch core. Counts rising edges of the divided tick level (already
// in the cin domain) into four BCD digits. A prescaler groups TICK_DIV edges
// into one second. Start/stop/clear arrive as single-cycle pulses from the
// debounced button stage.
//
// Parameters
//   TICK_DIV : tick_in rising edges per one-second increment (>= 1)
//   D3_MAX   : largest value of the minutes-tens digit (wrap point D3_MAX9:59)
//
// Ports
//   cin        in   system clock, all state on posedge cin
//   rst        in   synchronous, active-high reset
//   tick_in    in   divided clock level, edge-detected here
//   start_stop in   1-cycle pulse: start, pause or resume
//   clear      in   1-cycle pulse: zero the count while paused
//   lap        in   1-cycle pulse, only used when LAP_HOLD_EN is defined
//   d0..d3     out  BCD digits: sec units, sec tens, min units, min tens
//   running    out  high while the FSM is in RUN
//   wrap       out  1-cycle pulse when the count rolls over to 00:00
//
// Configuration macro
//   LAP_HOLD_EN : adds a lap-hold display register. While hold is set the
//                 digits show the captured count and the live count keeps
//                 running underneath. Undefined: lap is ignored.
// -----------------------------------------------------------------------------
module bcd_stopwatch_counter #(
    parameter int TICK_DIV = 1,
    parameter int D3_MAX   = 9
) (
    input  logic       cin,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic       running,
    output logic       wrap
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic             tick_q;
    logic [PW-1:0]    presc_q, presc_d;
    logic [3:0][3:0]  cnt_q, cnt_d;
    logic             wrap_q, wrap_d;

    // ------------------------------------------------------------------
    // Edge detect. tick_q resets high so a level that is already high at
    // reset release is not mistaken for a rising edge.
    // ------------------------------------------------------------------
    logic tick_edge;
    assign tick_edge = tick_in & ~tick_q;

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    logic zero_count;

    always_comb begin
        state_d    = state_q;
        zero_count = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_stop) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (start_stop) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                // clear takes priority over a simultaneous start_stop
                if (clear) begin
                    state_d    = ST_IDLE;
                    zero_count = 1'b1;
                end else if (start_stop) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                zero_count = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Prescaler. Counting is qualified by the current state, so an edge in
    // the cycle that leaves RUN still counts and one in the cycle that
    // enters RUN does not.
    // ------------------------------------------------------------------
    logic count_en;
    logic presc_last;
    logic sec_tick;

    assign count_en   = (state_q == ST_RUN) && tick_edge;
    assign presc_last = (presc_q == PW'(TICK_DIV - 1));
    assign sec_tick   = count_en && presc_last;

    always_comb begin
        presc_d = presc_q;
        if (zero_count) begin
            presc_d = '0;
        end else if (count_en) begin
            presc_d = presc_last ? '0 : presc_q + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // BCD digit chain. inc[gi] is the increment request into digit gi;
    // a digit sitting at its maximum passes the request on and rolls to 0.
    // A carry out of the top digit means the whole count was at max.
    // ------------------------------------------------------------------
    logic [4:0] inc;
    assign inc[0] = sec_tick;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            localparam logic [3:0] DMAX = (gi == 0) ? 4'd9 :
                                          (gi == 1) ? 4'd5 :
                                          (gi == 2) ? 4'd9 : 4'(D3_MAX);
            logic at_max;
            assign at_max     = (cnt_q[gi] == DMAX);
            assign inc[gi+1]  = inc[gi] & at_max;
            assign cnt_d[gi]  = zero_count ? 4'd0 :
                                !inc[gi]   ? cnt_q[gi] :
                                at_max     ? 4'd0 : cnt_q[gi] + 4'd1;
        end
    endgenerate

    assign wrap_d = inc[4];

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    always_ff @(posedge cin) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tick_q  <= 1'b1;
            presc_q <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_in;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    assign running = (state_q == ST_RUN);
    assign wrap    = wrap_q;

    // ------------------------------------------------------------------
    // Display path
    // ------------------------------------------------------------------
`ifdef LAP_HOLD_EN
    logic             hold_q, hold_d;
    logic [3:0][3:0]  disp_q, disp_d;

    always_comb begin
        hold_d = hold_q;
        disp_d = disp_q;
        if (state_d == ST_IDLE) begin
            hold_d = 1'b0;
        end else if (lap) begin
            if (state_q == ST_RUN) begin
                hold_d = ~hold_q;
                // Entering hold freezes the count as it stands this cycle
                if (!hold_q) disp_d = cnt_q;
            end else if (state_q == ST_PAUSE && hold_q) begin
                hold_d = 1'b0;
            end
        end
    end

    always_ff @(posedge cin) begin
        if (rst) begin
            hold_q <= 1'b0;
            disp_q <= '0;
        end else begin
            hold_q <= hold_d;
            disp_q <= disp_d;
        end
    end

    logic [3:0][3:0] shown;
    assign shown = hold_q ? disp_q : cnt_q;
    assign d0 = shown[0];
    assign d1 = shown[1];
    assign d2 = shown[2];
    assign d3 = shown[3];
`else
    logic unused_lap;
    assign unused_lap = lap;

    assign d0 = cnt_q[0];
    assign d1 = cnt_q[1];
    assign d2 = cnt_q[2];
    assign d3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
module tb_bcd_stopwatch_counter;

    logic       cin = 1'b0;
    logic       rst = 1'b1;
    logic       tick_in = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic       lap = 1'b0;

    logic [3:0] a_d0, a_d1, a_d2, a_d3;
    logic       a_running, a_wrap;
    logic [3:0] b_d0, b_d1, b_d2, b_d3;
    logic       b_running, b_wrap;

    int checks = 0;
    int failures = 0;

    always #5 cin = ~cin;

    // TICK_DIV = 1 instance
    bcd_stopwatch_counter #(.TICK_DIV(1), .D3_MAX(9)) dut_a (
        .cin(cin), .rst(rst), .tick_in(tick_in), .start_stop(start_stop),
        .clear(clear), .lap(lap),
        .d0(a_d0), .d1(a_d1), .d2(a_d2), .d3(a_d3),
        .running(a_running), .wrap(a_wrap)
    );

    // TICK_DIV = 4 instance, same stimulus
    bcd_stopwatch_counter #(.TICK_DIV(4), .D3_MAX(9)) dut_b (
        .cin(cin), .rst(rst), .tick_in(tick_in), .start_stop(start_stop),
        .clear(clear), .lap(lap),
        .d0(b_d0), .d1(b_d1), .d2(b_d2), .d3(b_d3),
        .running(b_running), .wrap(b_wrap)
    );

    function automatic logic [15:0] a_cnt();
        return {a_d3, a_d2, a_d1, a_d0};
    endfunction

    task automatic step();
        @(posedge cin);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick_in = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic press_ss();
        start_stop = 1'b1; step(); start_stop = 1'b0;
    endtask

    // One full tick period: rising edge sampled at the first posedge
    task automatic pulse_edge();
        tick_in = 1'b1; step();
        tick_in = 1'b0; step();
    endtask

    task automatic test_reset();
        rst = 1'b1; tick_in = 1'b1; step(); step();
        checks++;
        if (a_cnt() !== 16'h0000 || a_running !== 1'b0 || a_wrap !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got cnt=%h run=%b wrap=%b, want 0000 0 0",
                     a_cnt(), a_running, a_wrap);
        end
        rst = 1'b0;
        press_ss();
        // tick_in was already high at reset: no edge until it drops
        repeat (3) step();
        checks++;
        if (a_d0 !== 4'd0) begin
            failures++;
            $display("FAIL no_edge_while_high: got d0=%0d want 0", a_d0);
        end
        tick_in = 1'b0; step();
        tick_in = 1'b1;
        checks++;
        if (a_d0 !== 4'd0) begin
            failures++;
            $display("FAIL before_rise_sampled: got d0=%0d want 0", a_d0);
        end
        step();
        checks++;
        if (a_d0 !== 4'd1) begin
            failures++;
            $display("FAIL one_cycle_latency: got d0=%0d want 1", a_d0);
        end
        tick_in = 1'b0;
        $display("test_reset done d0=%0d", a_d0);
    endtask

    task automatic test_sixty();
        do_reset();
        press_ss();
        repeat (60) pulse_edge();
        checks++;
        if (a_cnt() !== 16'h0100 || a_running !== 1'b1) begin
            failures++;
            $display("FAIL sixty_edges: got cnt=%h run=%b want 0100 1", a_cnt(), a_running);
        end
        $display("test_sixty cnt=%h", a_cnt());
    endtask

    task automatic test_wrap();
        do_reset();
        press_ss();
        repeat (5999) pulse_edge();
        checks++;
        if (a_cnt() !== 16'h9959 || a_wrap !== 1'b0) begin
            failures++;
            $display("FAIL preload_max: got cnt=%h wrap=%b want 9959 0", a_cnt(), a_wrap);
        end
        tick_in = 1'b1; step();
        checks++;
        if (a_cnt() !== 16'h0000 || a_wrap !== 1'b1) begin
            failures++;
            $display("FAIL wrap_edge: got cnt=%h wrap=%b want 0000 1", a_cnt(), a_wrap);
        end
        tick_in = 1'b0; step();
        checks++;
        if (a_wrap !== 1'b0) begin
            failures++;
            $display("FAIL wrap_single_cycle: got wrap=%b want 0", a_wrap);
        end
        pulse_edge();
        checks++;
        if (a_cnt() !== 16'h0001) begin
            failures++;
            $display("FAIL count_after_wrap: got cnt=%h want 0001", a_cnt());
        end
        $display("test_wrap cnt=%h", a_cnt());
    endtask

    task automatic test_pause_clear();
        do_reset();
        // clear in IDLE does nothing, start still works next
        clear = 1'b1; step(); clear = 1'b0;
        press_ss();
        repeat (3) pulse_edge();
        // clear in RUN is ignored
        clear = 1'b1; step(); clear = 1'b0;
        checks++;
        if (a_cnt() !== 16'h0003 || a_running !== 1'b1) begin
            failures++;
            $display("FAIL clear_in_run: got cnt=%h run=%b want 0003 1", a_cnt(), a_running);
        end
        // stop and edge in the same cycle: the edge still counts
        tick_in = 1'b1; start_stop = 1'b1; step();
        start_stop = 1'b0; tick_in = 1'b0; step();
        checks++;
        if (a_cnt() !== 16'h0004 || a_running !== 1'b0) begin
            failures++;
            $display("FAIL stop_with_edge: got cnt=%h run=%b want 0004 0", a_cnt(), a_running);
        end
        repeat (2) pulse_edge();
        checks++;
        if (a_cnt() !== 16'h0004) begin
            failures++;
            $display("FAIL paused_hold: got cnt=%h want 0004", a_cnt());
        end
        // resume with an edge in the same cycle: not counted
        tick_in = 1'b1; start_stop = 1'b1; step();
        start_stop = 1'b0; tick_in = 1'b0; step();
        checks++;
        if (a_cnt() !== 16'h0004 || a_running !== 1'b1) begin
            failures++;
            $display("FAIL start_with_edge: got cnt=%h run=%b want 0004 1", a_cnt(), a_running);
        end
        press_ss();
        clear = 1'b1; start_stop = 1'b1; step();
        clear = 1'b0; start_stop = 1'b0;
        checks++;
        if (a_cnt() !== 16'h0000 || a_running !== 1'b0) begin
            failures++;
            $display("FAIL clear_beats_start: got cnt=%h run=%b want 0000 0", a_cnt(), a_running);
        end
        // still IDLE: edges do nothing
        pulse_edge();
        checks++;
        if (a_cnt() !== 16'h0000) begin
            failures++;
            $display("FAIL idle_no_count: got cnt=%h want 0000", a_cnt());
        end
        $display("test_pause_clear cnt=%h run=%b", a_cnt(), a_running);
    endtask

    task automatic test_prescaler();
        do_reset();
        press_ss();
        repeat (7) pulse_edge();
        checks++;
        if (b_d0 !== 4'd1) begin
            failures++;
            $display("FAIL div4_seven_edges: got d0=%0d want 1", b_d0);
        end
        press_ss();
        press_ss();
        pulse_edge();
        checks++;
        if (b_d0 !== 4'd2) begin
            failures++;
            $display("FAIL div4_resume_edge: got d0=%0d want 2", b_d0);
        end
        $display("test_prescaler d0=%0d", b_d0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        press_ss();
        repeat (9) pulse_edge();
        // carry from d0 into d1 then reset mid-count
        pulse_edge();
        checks++;
        if (a_cnt() !== 16'h0010) begin
            failures++;
            $display("FAIL carry_d1: got cnt=%h want 0010", a_cnt());
        end
        rst = 1'b1; tick_in = 1'b1; step(); rst = 1'b0; tick_in = 1'b0;
        checks++;
        if (a_cnt() !== 16'h0000 || a_running !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_count: got cnt=%h run=%b want 0000 0", a_cnt(), a_running);
        end
        $display("test_back_to_back cnt=%h", a_cnt());
    endtask

`ifdef LAP_HOLD_EN
    task automatic test_lap_hold();
        do_reset();
        press_ss();
        repeat (5) pulse_edge();
        lap = 1'b1; step(); lap = 1'b0;
        repeat (3) pulse_edge();
        checks++;
        if (a_cnt() !== 16'h0005) begin
            failures++;
            $display("FAIL lap_frozen: got cnt=%h want 0005", a_cnt());
        end
        lap = 1'b1; step(); lap = 1'b0;
        checks++;
        if (a_cnt() !== 16'h0008) begin
            failures++;
            $display("FAIL lap_release: got cnt=%h want 0008", a_cnt());
        end
        $display("test_lap_hold cnt=%h", a_cnt());
    endtask
`endif

    initial begin
        test_reset();
        test_sixty();
        test_wrap();
        test_pause_clear();
        test_prescaler();
        test_back_to_back();
`ifdef LAP_HOLD_EN
        test_lap_hold();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
